// File: rtl/burst_pipeline_pkg.sv
// Shared definitions for the burst read/write pipelines: T0 counter encodings,
// the decoded T0 state and the burst-length clamp.
package burst_pipeline_pkg;

    localparam int unsigned BURST_LEN_WIDTH = 8;

    localparam logic [BURST_LEN_WIDTH-1:0] BURST_IDLE = 8'hFF;
    localparam logic [BURST_LEN_WIDTH-1:0] BURST_LAST = 8'h00;

    typedef enum logic [1:0] {
        T0_IDLE,
        T0_BURST,
        T0_LAST
    } t0_state_e;

    // Requests longer than the maximum are silently truncated to max_burst beats.
    function automatic logic [BURST_LEN_WIDTH-1:0] clamp_length(
        input logic [BURST_LEN_WIDTH-1:0] length,
        input int unsigned                max_burst
    );
        logic [BURST_LEN_WIDTH-1:0] max_m1;
        max_m1 = BURST_LEN_WIDTH'(max_burst - 1);
        return (length > max_m1) ? max_m1 : length;
    endfunction

    function automatic t0_state_e decode_count(input logic [BURST_LEN_WIDTH-1:0] count);
        if (count == BURST_IDLE) begin
            return T0_IDLE;
        end else if (count == BURST_LAST) begin
            return T0_LAST;
        end
        return T0_BURST;
    endfunction

endpackage

// File: rtl/burst_addr_counter.sv
// T0 stage of the burst pipelines: holds the remaining beat count and the
// current word address, and accepts a new burst when idle or on the last beat.
module burst_addr_counter
    import burst_pipeline_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int MAX_BURST_LENGTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       load_valid,
    input  logic [ADDR_WIDTH-1:0]      load_addr,
    input  logic [BURST_LEN_WIDTH-1:0] load_length,
    output logic [BURST_LEN_WIDTH-1:0] count,
    output logic [ADDR_WIDTH-1:0]      addr,
    output logic                       valid,
    output logic                       ready
);

    t0_state_e                  state;
    logic [BURST_LEN_WIDTH-1:0] count_next;
    logic [ADDR_WIDTH-1:0]      addr_next;
    logic                       valid_next;

    always_comb begin
        state = decode_count(count);
        ready = (state == T0_IDLE) || (state == T0_LAST);
    end

    // Without a new request the counter returns to idle rather than reloading,
    // so a stale length never produces phantom beats.
    always_comb begin
        count_next = count;
        addr_next  = addr;
        valid_next = valid;
        if (en) begin
            case (state)
                T0_IDLE, T0_LAST: begin
                    addr_next = load_addr;
                    if (load_valid) begin
                        count_next = clamp_length(load_length, MAX_BURST_LENGTH);
                        valid_next = 1'b1;
                    end else begin
                        count_next = BURST_IDLE;
                        valid_next = 1'b0;
                    end
                end
                default: begin
                    count_next = count - BURST_LEN_WIDTH'(1);
                    addr_next  = addr + ADDR_WIDTH'(1);
                    valid_next = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= BURST_IDLE;
            addr  <= '0;
            valid <= 1'b0;
        end else begin
            count <= count_next;
            addr  <= addr_next;
            valid <= valid_next;
        end
    end

endmodule

// File: rtl/burst_read_pipeline.sv
// Burst read pipeline: T0 address counter -> T1 synchronous memory read ->
// T2 output register, all stages advancing on one shared enable.
module burst_read_pipeline
    import burst_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int MAX_BURST_LENGTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] u_addr,
    input  logic [7:0]            u_length,
    input  logic                  u_valid,
    output logic                  u_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_last,
    output logic                  d_valid,
    input  logic                  d_ready
);

    logic                       en;
    logic [BURST_LEN_WIDTH-1:0] t0_count;
    logic [ADDR_WIDTH-1:0]      t0_addr;
    logic                       t0_valid;
    logic                       t0_ready;
    logic                       t1_valid;
    logic                       t1_last;

    assign en = d_ready || !d_valid;

    burst_addr_counter #(
        .ADDR_WIDTH       (ADDR_WIDTH),
        .MAX_BURST_LENGTH (MAX_BURST_LENGTH)
    ) u_t0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load_valid  (u_valid),
        .load_addr   (u_addr),
        .load_length (u_length),
        .count       (t0_count),
        .addr        (t0_addr),
        .valid       (t0_valid),
        .ready       (t0_ready)
    );

    assign u_ready  = t0_ready && en;
    assign mem_addr = t0_addr;
    // Gating the read with en keeps mem_rdata matched to the beat held in T1.
    assign mem_re   = t0_valid && en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_valid <= 1'b0;
            t1_last  <= 1'b0;
        end else if (en) begin
            t1_valid <= t0_valid;
            t1_last  <= (t0_count == BURST_LAST) && t0_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_last  <= 1'b0;
            d_data  <= '0;
        end else if (en) begin
            d_valid <= t1_valid;
            d_last  <= t1_last;
            d_data  <= mem_rdata;
        end
    end

endmodule
